// File: rtl/imem_fetch_unit_pkg.sv
// Shared types and address-decode helper for the instruction fetch unit.
package imem_fetch_unit_pkg;

   localparam int unsigned DEC_ADDR_W = 64;
   localparam int unsigned DEC_IDX_W  = 16;
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic                 fault;
      logic [DEC_IDX_W-1:0] idx;
   } addr_dec_t;

   // Word index plus fault for misaligned or beyond-depth byte addresses.
   function automatic addr_dec_t addr_decode(input logic [DEC_ADDR_W-1:0] addr,
                                             input int unsigned depth);
      addr_dec_t d;
      d.fault = (addr[1:0] != 2'b00) ||
                (addr[DEC_ADDR_W-1:2] >= (DEC_ADDR_W-2)'(depth));
      d.idx   = addr[DEC_IDX_W+1:2] & DEC_IDX_W'(depth - 1);
      return d;
   endfunction

endpackage

// File: rtl/imem_fetch_unit_ram.sv
// Instruction store: single write port, registered read port with enable.
module imem_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Read sees the pre-write contents when both ports hit the same word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: NOP-fills memory after reset, then serves 1-cycle
// fetches with valid/ready handshake and accepts program-load writes.
module imem_fetch_unit
   import imem_fetch_unit_pkg::*;
#(
   parameter int unsigned      ADDR_W   = 32,
   parameter int unsigned      DATA_W   = 32,
   parameter int unsigned      DEPTH    = 256,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic              rsp_fault,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_err,
   output logic              init_done
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  fill_q, fill_d;
   logic              ram_we;
   logic [IDX_W-1:0]  ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_re;
   addr_dec_t         req_dec, ld_dec;
   logic              accept_c;
   logic              rsp_valid_q, rsp_fault_q, rd_ok_q, ld_err_q, init_done_q;

   assign req_dec = addr_decode(DEC_ADDR_W'(req_addr), DEPTH);
   assign ld_dec  = addr_decode(DEC_ADDR_W'(ld_addr), DEPTH);

   assign req_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
   assign accept_c  = req_valid && req_ready;
   assign ram_re    = accept_c && !req_dec.fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
      end
   end

   // Fill sequencing in INIT; load-port write steering in RUN.
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      ram_we    = 1'b0;
      ram_waddr = IDX_W'(ld_dec.idx);
      ram_wdata = ld_data;
      case (state_q)
         INIT: begin
            ram_we    = 1'b1;
            ram_waddr = fill_q;
            ram_wdata = NOP_WORD;
            fill_d    = fill_q + IDX_W'(1);
            if (fill_q == IDX_W'(DEPTH - 1)) state_d = RUN;
         end
         RUN: begin
            ram_we = ld_en && !ld_dec.fault;
         end
         default: state_d = INIT;
      endcase
   end

   // Response holds while stalled; rd_ok_q selects RAM data over the NOP word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rd_ok_q     <= 1'b0;
         ld_err_q    <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         if (accept_c) begin
            rsp_valid_q <= 1'b1;
            rsp_fault_q <= req_dec.fault;
            rd_ok_q     <= !req_dec.fault;
         end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
         ld_err_q    <= (state_q == RUN) && ld_en && ld_dec.fault;
         init_done_q <= (state_d == RUN);
      end
   end

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (IDX_W'(req_dec.idx)),
      .rdata (ram_rdata)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_fault = rsp_fault_q;
   assign rsp_instr = rd_ok_q ? ram_rdata : NOP_WORD;
   assign ld_err    = ld_err_q;
   assign init_done = init_done_q;

endmodule

// File: doc/imem_fetch_unit.md
IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 256, number of words; power of two, 2..65536.
REQ-004 Parameter NOP_WORD, default 32'h00000013, fill and fault word (addi x0,x0,0).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  in  1  fetch request present.
REQ-008 req_ready  out  1  fetch request accepted this cycle if req_valid.
REQ-009 req_addr  in  ADDR_W  fetch byte address.
REQ-010 rsp_valid  out  1  response present.
REQ-011 rsp_ready  in  1  consumer takes response this cycle.
REQ-012 rsp_instr  out  DATA_W  fetched instruction.
REQ-013 rsp_fault  out  1  fetch address misaligned or out of range.
REQ-014 ld_en  in  1  program-load write strobe.
REQ-015 ld_addr  in  ADDR_W  load byte address.
REQ-016 ld_data  in  DATA_W  load word.
REQ-017 ld_err  out  1  one-cycle pulse: load rejected.
REQ-018 init_done  out  1  memory fill complete, unit operational.

Function
REQ-019 FSM states: INIT, RUN; reset enters INIT with fill index 0.
REQ-020 INIT: write NOP_WORD to mem[index], index+1 per cycle; after writing DEPTH-1, next state RUN; INIT lasts exactly DEPTH cycles.
REQ-021 In INIT: req_ready=0, init_done=0, ld_en ignored without ld_err.
REQ-022 RUN: init_done=1; req_ready = !rsp_valid || rsp_ready (combinational).
REQ-023 Word index = req_addr[log2(DEPTH)+1:2]; fault when req_addr[1:0]!=0 or req_addr[ADDR_W-1:2] >= DEPTH.
REQ-024 Accepted request (req_valid && req_ready) produces rsp_valid=1 on the next cycle; latency exactly 1.
REQ-025 rsp_instr = mem[index], rsp_fault=0 on legal address; rsp_instr=NOP_WORD, rsp_fault=1 on fault.
REQ-026 While rsp_valid && !rsp_ready: rsp_instr, rsp_fault, rsp_valid held stable; no new request accepted.
REQ-027 rsp_ready with no new accept: rsp_valid deasserts next cycle; with accept: back-to-back, one response per cycle.
REQ-028 RUN ld_en with legal ld_addr: mem[index] <= ld_data at the edge; loads are independent of fetch stall.
REQ-029 ld_en with misaligned or out-of-range ld_addr: no write, ld_err=1 for the next cycle only.
REQ-030 Same-cycle accepted fetch and load to same index: fetch returns the old word (read-before-write).
REQ-031 Held response is not updated by a later load to its index.

Reset
REQ-032 On rst_n low: state=INIT, index=0, rsp_valid=0, rsp_instr=NOP_WORD, rsp_fault=0, ld_err=0, init_done=0, req_ready=0.
REQ-033 Reset mid-INIT or mid-RUN discards any pending response and restarts the full fill.
REQ-034 Memory array itself has no reset; contents are defined only by the INIT fill.

Structure
REQ-035 Shared package holds the FSM state enum, default NOP_WORD and the address-decode helper (index, fault).
REQ-036 One sub-module imem_ram: DEPTH x DATA_W single-write, synchronous-read array; all control in the parent.

Verification
REQ-037 Reset release, DEPTH=16: init_done=0 for 16 cycles, then 1; fetch 0x0..0x3C all return 0x00000013, fault=0.
REQ-038 Load 0x00100093 at 0x8, fetch 0x8 -> next cycle rsp_valid=1, rsp_instr=0x00100093; fetch 0x6 -> rsp_fault=1, rsp_instr=0x00000013.
REQ-039 Fetch 0x40 with DEPTH=16 -> rsp_fault=1; ld_en to 0x40 -> ld_err pulse 1 cycle, mem unchanged.
REQ-040 rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_instr stable; rsp_ready=1 -> streaming 1 word/cycle.
REQ-041 Same cycle: fetch 0x4 and load 0xDEADBEEF at 0x4 -> response is old word; next fetch 0x4 -> 0xDEADBEEF.
REQ-042 rst_n pulsed low during stalled response -> rsp_valid=0 immediately, INIT restarts, prior loads overwritten with NOP.
